// File: rtl/freq_sweep_measure_ctrl_pkg.sv
// Shared definitions for the frequency-sweep measurement initiator.
// Holds the sweep FSM state type, the default data widths and the default
// measurement window. The window length is shared with the mean-current
// measurement block. Also holds a helper that sizes the duration counter.
package freq_sweep_measure_ctrl_pkg;

    localparam int unsigned FREQ_W_DEF     = 8;
    localparam int unsigned CURR_W_DEF     = 12;
    localparam int unsigned WINDOW_CYC_DEF = 40000;  // 0x9C40, same as the measurement block

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StCapture,
        StNext,
        StDone
    } sweep_state_e;

    // Width of a down-counter that must hold values up to max(a, b) - 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/freq_sweep_measure_ctrl_sweep_timer.sv
// Load / count / terminal-count down-counter used for the settle and
// measurement durations of the sweep.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (has priority over en)
//   load_val - value to load; tc then asserts load_val cycles later
//   en       - decrement while non-zero
//   tc       - terminal count, high when the count is zero
module freq_sweep_measure_ctrl_sweep_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/freq_sweep_measure_ctrl.sv
// Frequency-sweep measurement initiator.
// Steps freq_code through N_STEPS codes. Each step holds the code for
// SETTLE_CYC cycles, raises measure for WINDOW_CYC cycles, then captures
// mean_curr. At the end of the sweep it publishes the code with the highest
// current. On a tie the earliest code is kept.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   swiptAlive        - link alive; dropping it aborts a sweep in progress
//   start             - single-cycle sweep request, honoured only in idle
//   mean_curr         - result from the measurement block, held after measure falls
//   measure           - measurement window strobe
//   freq_code         - frequency code under test
//   busy              - sweep in progress, including the final publish cycle
//   done / aborted    - one-cycle completion / abort pulses
//   best_freq/curr    - last published best code and its current
// All outputs are registered.
module freq_sweep_measure_ctrl
    import freq_sweep_measure_ctrl_pkg::*;
#(
    parameter int unsigned FREQ_W     = FREQ_W_DEF,
    parameter int unsigned CURR_W     = CURR_W_DEF,
    parameter int unsigned F_START    = 0,
    parameter int unsigned F_STEP     = 1,
    parameter int unsigned N_STEPS    = 16,
    parameter int unsigned SETTLE_CYC = 1000,
    parameter int unsigned WINDOW_CYC = WINDOW_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swiptAlive,
    input  logic              start,
    input  logic [CURR_W-1:0] mean_curr,
    output logic              measure,
    output logic [FREQ_W-1:0] freq_code,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [FREQ_W-1:0] best_freq,
    output logic [CURR_W-1:0] best_curr
);

    localparam int unsigned CNT_W  = cnt_width(SETTLE_CYC, WINDOW_CYC);
    localparam int unsigned STEP_W = $clog2(N_STEPS) + 1;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  WINDOW_LOAD = CNT_W'(WINDOW_CYC - 1);
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(N_STEPS - 1);
    localparam logic [FREQ_W-1:0] FREQ_FIRST  = FREQ_W'(F_START);
    localparam logic [FREQ_W-1:0] FREQ_INC    = FREQ_W'(F_STEP);

    sweep_state_e      state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [FREQ_W-1:0] run_best_freq_q, run_best_freq_d;
    logic [CURR_W-1:0] run_best_curr_q, run_best_curr_d;
    logic [FREQ_W-1:0] best_freq_q, best_freq_d;
    logic [CURR_W-1:0] best_curr_q, best_curr_d;
    logic              measure_q, busy_q, done_q, aborted_q;
    logic              done_d, aborted_d;

    logic              tmr_load, tmr_en, tmr_tc;
    logic [CNT_W-1:0]  tmr_load_val;

    freq_sweep_measure_ctrl_sweep_timer #(
        .CNT_W (CNT_W)
    ) u_sweep_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        freq_d          = freq_q;
        run_best_freq_d = run_best_freq_q;
        run_best_curr_d = run_best_curr_q;
        best_freq_d     = best_freq_q;
        best_curr_d     = best_curr_q;
        done_d          = 1'b0;
        aborted_d       = 1'b0;
        tmr_load        = 1'b0;
        tmr_load_val    = '0;
        tmr_en          = 1'b0;

        if ((state_q != StIdle) && !swiptAlive) begin
            // Link lost: drop everything, keep freq_code and published results.
            state_d   = StIdle;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && swiptAlive) begin
                        state_d      = StSettle;
                        freq_d       = FREQ_FIRST;
                        step_d       = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                    end
                end
                StSettle: begin
                    if (tmr_tc) begin
                        state_d      = StMeasure;
                        tmr_load     = 1'b1;
                        tmr_load_val = WINDOW_LOAD;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                StMeasure: begin
                    if (tmr_tc) begin
                        state_d = StCapture;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                StCapture: begin
                    // Strict compare so the earliest code wins a tie.
                    if ((step_q == '0) || (mean_curr > run_best_curr_q)) begin
                        run_best_curr_d = mean_curr;
                        run_best_freq_d = freq_q;
                    end
                    state_d = StNext;
                end
                StNext: begin
                    if (step_q == LAST_STEP) begin
                        state_d = StDone;
                    end else begin
                        state_d      = StSettle;
                        step_d       = step_q + 1'b1;
                        freq_d       = freq_q + FREQ_INC;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LOAD;
                    end
                end
                StDone: begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    best_freq_d = run_best_freq_q;
                    best_curr_d = run_best_curr_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            step_q          <= '0;
            freq_q          <= FREQ_FIRST;
            run_best_freq_q <= FREQ_FIRST;
            run_best_curr_q <= '0;
            best_freq_q     <= FREQ_FIRST;
            best_curr_q     <= '0;
            measure_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            step_q          <= step_d;
            freq_q          <= freq_d;
            run_best_freq_q <= run_best_freq_d;
            run_best_curr_q <= run_best_curr_d;
            best_freq_q     <= best_freq_d;
            best_curr_q     <= best_curr_d;
            // Strobes decode the next state so they line up with it.
            measure_q       <= (state_d == StMeasure);
            busy_q          <= (state_d != StIdle);
            done_q          <= done_d;
            aborted_q       <= aborted_d;
        end
    end

    assign measure   = measure_q;
    assign freq_code = freq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign best_freq = best_freq_q;
    assign best_curr = best_curr_q;

endmodule

// File: tb/tb_freq_sweep_measure_ctrl.sv
// Bench for freq_sweep_measure_ctrl. Two instances share clock and reset:
// instance 0 uses a normal sweep, instance 1 uses a sweep whose codes wrap.
// Expected outputs come from the sweep timeline: cycle n after start lies in
// step n / P at phase n % P, with P = SETTLE + WINDOW + 2.
module tb_freq_sweep_measure_ctrl;

    logic       clk;
    logic       rst;
    logic       start_s   [2];
    logic       alive_s   [2];
    logic [11:0] curr_s   [2];
    logic       measure_s [2];
    logic [7:0] freq_s    [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic       aborted_s [2];
    logic [7:0] bfreq_s   [2];
    logic [11:0] bcurr_s  [2];

    int checks;
    int errors;
    int exp_freq [2];
    int exp_bf   [2];
    int exp_bc   [2];

    freq_sweep_measure_ctrl #(
        .FREQ_W(8), .CURR_W(12), .F_START(10), .F_STEP(2), .N_STEPS(4),
        .SETTLE_CYC(4), .WINDOW_CYC(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .swiptAlive(alive_s[0]), .start(start_s[0]),
        .mean_curr(curr_s[0]), .measure(measure_s[0]), .freq_code(freq_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .aborted(aborted_s[0]),
        .best_freq(bfreq_s[0]), .best_curr(bcurr_s[0])
    );

    freq_sweep_measure_ctrl #(
        .FREQ_W(8), .CURR_W(12), .F_START(254), .F_STEP(1), .N_STEPS(4),
        .SETTLE_CYC(3), .WINDOW_CYC(5)
    ) u_dut_b (
        .clk(clk), .rst(rst), .swiptAlive(alive_s[1]), .start(start_s[1]),
        .mean_curr(curr_s[1]), .measure(measure_s[1]), .freq_code(freq_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .aborted(aborted_s[1]),
        .best_freq(bfreq_s[1]), .best_curr(bcurr_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int cfg_s(input int d);     return (d == 0) ? 4 : 3;     endfunction
    function automatic int cfg_w(input int d);     return (d == 0) ? 8 : 5;     endfunction
    function automatic int cfg_fs(input int d);    return (d == 0) ? 10 : 254;  endfunction
    function automatic int cfg_fstep(input int d); return (d == 0) ? 2 : 1;     endfunction
    function automatic int cfg_n(input int d);     return 4;                    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_idle(input int d);
        check("idle_measure", 32'(measure_s[d]), 32'd0);
        check("idle_busy", 32'(busy_s[d]), 32'd0);
        check("idle_done", 32'(done_s[d]), 32'd0);
        check("idle_aborted", 32'(aborted_s[d]), 32'd0);
        check("idle_freq", 32'(freq_s[d]), 32'(exp_freq[d]));
        check("best_freq", 32'(bfreq_s[d]), 32'(exp_bf[d]));
        check("best_curr", 32'(bcurr_s[d]), 32'(exp_bc[d]));
    endtask

    // One sweep on instance d. abort_n >= 0 drops swiptAlive during cycle
    // abort_n; busy_start_n >= 0 pulses start during that (busy) cycle.
    task automatic run_sweep(input int d, input int v0, input int v1, input int v2,
                             input int v3, input int abort_n, input int busy_start_n);
        int s, w, p, nst, fs, fstep, total, k, ph, best_i, first_done, pulses;
        int vals[4];
        logic prev_meas;
        s = cfg_s(d); w = cfg_w(d); nst = cfg_n(d); fs = cfg_fs(d); fstep = cfg_fstep(d);
        p = s + w + 2;
        total = nst * p;
        vals = '{v0, v1, v2, v3};
        best_i = 0;
        for (int i = 1; i < nst; i++) if (vals[i] > vals[best_i]) best_i = i;
        first_done = -1;
        pulses = 0;
        prev_meas = 1'b0;

        start_s[d] = 1'b1;
        alive_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;

        for (int n = 0; n <= total + 1; n++) begin
            k = n / p;
            ph = n % p;
            if (abort_n >= 0 && n == abort_n + 1) begin
                check("abort_measure", 32'(measure_s[d]), 32'd0);
                check("abort_busy", 32'(busy_s[d]), 32'd0);
                check("abort_pulse", 32'(aborted_s[d]), 32'd1);
                check("abort_done", 32'(done_s[d]), 32'd0);
                exp_freq[d] = (fs + ((abort_n < total) ? abort_n / p : nst - 1) * fstep) % 256;
                check("abort_freq", 32'(freq_s[d]), 32'(exp_freq[d]));
                alive_s[d] = 1'b1;
                @(posedge clk); #1;
                check("abort_one_cycle", 32'(aborted_s[d]), 32'd0);
                check("abort_stay_idle", 32'(busy_s[d]), 32'd0);
                check("abort_best_freq", 32'(bfreq_s[d]), 32'(exp_bf[d]));
                check("abort_best_curr", 32'(bcurr_s[d]), 32'(exp_bc[d]));
                return;
            end
            check("measure", 32'(measure_s[d]), 32'((n < total) && (ph >= s) && (ph < s + w)));
            check("busy", 32'(busy_s[d]), 32'(n <= total));
            check("done", 32'(done_s[d]), 32'(n == total + 1));
            check("aborted", 32'(aborted_s[d]), 32'd0);
            check("freq_code", 32'(freq_s[d]),
                  32'((fs + ((n < total) ? k : nst - 1) * fstep) % 256));
            if (done_s[d] === 1'b1 && first_done < 0) first_done = n;
            if (measure_s[d] === 1'b1 && prev_meas !== 1'b1) pulses++;
            prev_meas = measure_s[d];
            // Valid result only in the capture cycle; noise elsewhere.
            curr_s[d] = (n < total && ph == s + w) ? 12'(vals[k]) : 12'($urandom_range(0, 4095));
            start_s[d] = (n == busy_start_n);
            if (n == abort_n) alive_s[d] = 1'b0;
            @(posedge clk); #1;
        end
        start_s[d] = 1'b0;
        check("done_latency", 32'(first_done), 32'(total + 1));
        check("measure_pulses", 32'(pulses), 32'(nst));
        exp_bf[d] = (fs + best_i * fstep) % 256;
        exp_bc[d] = vals[best_i];
        exp_freq[d] = (fs + (nst - 1) * fstep) % 256;
        check("best_freq", 32'(bfreq_s[d]), 32'(exp_bf[d]));
        check("best_curr", 32'(bcurr_s[d]), 32'(exp_bc[d]));
        check("post_busy", 32'(busy_s[d]), 32'd0);
        check("post_done", 32'(done_s[d]), 32'd0);
    endtask

    initial begin
        int d, tot, ab, bs;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b1;
            alive_s[i] = 1'b1;
            curr_s[i] = 12'd0;
            exp_freq[i] = cfg_fs(i);
            exp_bf[i] = cfg_fs(i);
            exp_bc[i] = 0;
        end
        rst = 1'b1;
        // Reset held with start asserted: nothing may move.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) check_idle(i);
        end
        rst = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        @(posedge clk); #1;
        check_idle(0);
        check_idle(1);

        // Tie on 300: earlier code 12 wins; extra start while busy ignored.
        run_sweep(0, 100, 300, 200, 300, -1, 5);
        check_idle(0);
        // Abort on the 3rd measure cycle of step 2.
        run_sweep(0, 400, 50, 60, 70, 2 * 14 + 4 + 2, -1);
        check_idle(0);
        // Wrapping codes FE, FF, 00, 01.
        run_sweep(1, 5, 5, 9, 5, -1, -1);
        check_idle(1);

        // start with link down in idle: no sweep, no abort pulse.
        for (int i = 0; i < 2; i++) begin
            alive_s[i] = 1'b0;
            start_s[i] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start_s[0] = 1'b0;
            start_s[1] = 1'b0;
            check_idle(0);
            check_idle(1);
        end
        alive_s[0] = 1'b1;
        alive_s[1] = 1'b1;

        // Randomized sweeps with coarse currents so ties are common.
        for (int r = 0; r < 10; r++) begin
            d = int'($urandom_range(0, 1));
            tot = cfg_n(d) * (cfg_s(d) + cfg_w(d) + 2);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot)) : -1;
            bs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run_sweep(d, int'($urandom_range(0, 3)) * 1000, int'($urandom_range(0, 3)) * 1000,
                      int'($urandom_range(0, 3)) * 1000, int'($urandom_range(0, 3)) * 1000,
                      ab, bs);
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk); #1;
            end
            check_idle(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_sweep_measure_ctrl.md
Name: freq_sweep_measure_ctrl

Overview:
Initiator side of the mean-current measurement interface. It steps a frequency code through N_STEPS values. For each step it waits a settle time, then drives `measure` high for a fixed window, then captures the resulting `mean_curr`. At the end of the sweep it publishes the frequency code that gave the highest mean current. It sits between the SWIPT frequency algorithm (which issues `start`) and the mean-current measurement block (which consumes `measure` and returns `mean_curr`).

Parameters:
FREQ_W, 8, width of frequency code
CURR_W, 12, width of mean_curr
F_START, 0, first frequency code of the sweep
F_STEP, 1, code increment per step (modulo 2^FREQ_W)
N_STEPS, 16, number of steps per sweep (≥1)
SETTLE_CYC, 1000, cycles freq_code is held before measure rises (≥1)
WINDOW_CYC, 40000, cycles measure stays high per step (≥1; default matches the measurement block's 0x9C40 window)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
swiptAlive  in  1  link alive; low aborts any sweep
start  in  1  single-cycle sweep request
mean_curr  in  CURR_W  mean current from the measurement block
measure  out  1  measurement window strobe
freq_code  out  FREQ_W  frequency code under test
busy  out  1  high from SETTLE to DONE inclusive
done  out  1  one-cycle pulse when a sweep completes
aborted  out  1  one-cycle pulse when swiptAlive drops mid-sweep
best_freq  out  FREQ_W  published best code
best_curr  out  CURR_W  published best mean current

Behaviour:
- Reset (rst=1 at a clk edge) takes effect on that edge and overrides everything:
  - state=IDLE, measure=0, freq_code=F_START, busy=0, done=0, aborted=0, best_freq=F_START, best_curr=0.
  - Cycle counter and step index are cleared to 0.
- States: IDLE, SETTLE, MEASURE, CAPTURE, NEXT, DONE.
- IDLE:
  - start=1 && swiptAlive=1 → SETTLE; freq_code<=F_START; step_idx<=0; cnt<=0.
  - start is ignored in every other state, and in IDLE while swiptAlive=0.
- SETTLE: measure=0; stays exactly SETTLE_CYC cycles, then → MEASURE.
- MEASURE: measure=1 for exactly WINDOW_CYC consecutive cycles; freq_code is stable throughout; then → CAPTURE.
- CAPTURE: measure=0; lasts 1 cycle.
  - Samples mean_curr in this cycle. The measurement block holds its last window result after measure falls.
  - step_idx=0: run_best_curr<=mean_curr and run_best_freq<=freq_code unconditionally.
  - Otherwise update only if mean_curr > run_best_curr (strictly greater, unsigned), so on ties the earliest code wins.
- NEXT: lasts 1 cycle.
  - If step_idx==N_STEPS-1 → DONE.
  - Else step_idx+1, freq_code<=freq_code+F_STEP (wraps mod 2^FREQ_W), cnt<=0 → SETTLE.
- DONE: lasts 1 cycle; done=1; best_freq<=run_best_freq; best_curr<=run_best_curr; → IDLE.
- Per-step length is SETTLE_CYC+WINDOW_CYC+2 cycles. done is high exactly 1+N_STEPS*(SETTLE_CYC+WINDOW_CYC+2) cycles after the edge that samples start.
- Abort:
  - swiptAlive=0 in any non-IDLE state → next edge goes to IDLE with measure=0, busy=0, aborted=1 for one cycle.
  - best_* keep their previously published values; run_best_* are discarded.
  - freq_code keeps its last value.
  - swiptAlive=0 while IDLE produces no aborted pulse.
- busy is 1 in SETTLE, MEASURE, CAPTURE, NEXT and DONE, and 0 in IDLE.
- All outputs are registered; no combinational path from input to output.
- Cycle counter is wide enough for max(SETTLE_CYC, WINDOW_CYC) ($clog2, min 1 bit). Step index is $clog2(N_STEPS)+1 bits.

Decomposition:
- Shared package: state enum (6 states, 3-bit), default CURR_W/FREQ_W constants, WINDOW_CYC default 40000 (shared with the measurement block).
- One natural sub-module: sweep_timer, a load/count/terminal-count down-counter used for both the SETTLE and MEASURE durations.

Test Plan:
1. Reset: assert rst 3 cycles with start=1 → measure=0, busy=0, done=0, aborted=0, freq_code=F_START, best_freq=F_START, best_curr=0; no state change while rst=1.
2. Sweep (SETTLE_CYC=4, WINDOW_CYC=8, N_STEPS=4, F_START=10, F_STEP=2); the mean_curr model returns 100, 300, 200, 300 per window:
   - Expect best_freq=12, best_curr=300 (tie keeps the earlier code).
   - Expect done exactly 57 cycles after start.
3. Same configuration as scenario 2:
   - measure high in exactly 4 pulses of 8 cycles each, each preceded by 4 low settle cycles.
   - freq_code runs 10, 12, 14, 16 and is constant during each pulse.
4. Abort: drop swiptAlive on the 3rd MEASURE cycle of step 2 → next cycle measure=0, busy=0, aborted=1 for one cycle, no done pulse, best_* unchanged from scenario 2.
5. Ignored requests:
   - start pulsed while busy → sweep unaffected; total measure pulses stay at 4.
   - start with swiptAlive=0 in IDLE → busy stays 0.
6. Wrap: F_START=8'hFE, F_STEP=1, N_STEPS=4 → freq_code runs FE, FF, 00, 01. With mean_curr 5, 5, 9, 5 → best_freq=8'h00, best_curr=9.
